fifo_reader: RTL and testbench

//   Read-side controller for the 16-bit synchronous FIFO.
//   - Drains the FIFO via its readp/emptyp/dout interface.
//   - Presents the words downstream as a valid/ready stream.
//   - Hides the FIFO's one-cycle read latency behind a 2-entry output buffer.
//   - Sustains 1 word/cycle with no loss or reordering under backpressure.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 61 ++++++
 rtl/fifo_reader.sv | 58 +++++
 tb/tb_fifo_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and occupancy encoding for the FIFO read-side controller.
package fifo_pkg;
  localparam int          FIFO_WIDTH = 16;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_e;

  // Buffer level after this edge if nothing new is requested.
  function automatic logic [2:0] occ_after(occ_e s, logic cap, logic pop);
    return {1'b0, s} + {2'b00, cap} - {2'b00, pop};
  endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: head feeds the stream, tail absorbs the word that
// lands while the head is stalled.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             cap,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output occ_e             state
);
  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_EMPTY;
      valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
      valid <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: if (cap) begin
          head  <= din;
          state <= S_ONE;
          valid <= 1'b1;
        end
        S_ONE: case ({cap, pop})
          2'b10: begin
            tail  <= din;
            state <= S_TWO;
          end
          2'b11: head <= din;
          2'b01: begin
            state <= S_EMPTY;
            valid <= 1'b0;
          end
          default: ;
        endcase
        // A capture without a pop cannot occur here: readp was held off.
        S_TWO: if (pop) begin
          head <= tail;
          if (cap) tail <= din;
          else     state <= S_ONE;
        end
        default: begin
          state <= S_EMPTY;
          valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: drains a 1-cycle-latency FIFO into a valid/ready stream.
// Define FIFO_READER_CNT_EN to add the saturating rd_count output.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             emptyp,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             readp,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]      rd_count
`endif
);
  logic inflight;
  logic pop;
  occ_e state;

  assign pop = out_valid & out_ready;

  // Only request when the word is guaranteed a slot on arrival.
  assign readp = rstn & rd_en & ~emptyp & ~flush &
                 (occ_after(state, inflight, pop) < 3'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) inflight <= 1'b0;
    else       inflight <= readp;
  end

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .cap   (inflight),
    .pop   (pop),
    .din   (fifo_dout),
    .head  (out_data),
    .valid (out_valid),
    .state (state)
  );

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          rd_count <= '0;
    else if (flush)                     rd_count <= '0;
    else if (pop && rd_count != CNT_MAX) rd_count <= rd_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader with a queue-based FIFO and buffer model.
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rstn, rd_en, flush, out_ready;
  logic        emptyp, readp, out_valid;
  logic [15:0] fifo_dout = '0;
  logic [15:0] out_data;
`ifdef FIFO_READER_CNT_EN
  logic [15:0] rd_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // FIFO contents: src[rd_ptr..wr_cnt-1] are still queued in the FIFO.
  logic [15:0] src [$];
  int          wr_cnt = 0;
  int          rd_ptr = 0;
  int          underflow_cnt = 0;
  // Expected buffer contents and the word travelling from the FIFO.
  logic [15:0] mbuf [$];
  logic        m_inf = 1'b0;
  logic [15:0] m_inf_d = '0;

  always #5 clk = ~clk;

  assign emptyp = (rd_ptr >= wr_cnt);

  fifo_reader dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_en     (rd_en),
    .flush     (flush),
    .emptyp    (emptyp),
    .fifo_dout (fifo_dout),
    .readp     (readp),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FIFO_READER_CNT_EN
    ,
    .rd_count  (rd_count)
`endif
  );

  // FIFO read port plus reference buffer; the FIFO shares the system reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= wr_cnt;
      mbuf.delete();
      m_inf = 1'b0;
    end else begin
      if (flush) mbuf.delete();
      else begin
        if (mbuf.size() != 0 && out_ready) void'(mbuf.pop_front());
        if (m_inf) mbuf.push_back(m_inf_d);
      end
      m_inf = 1'b0;
      if (readp) begin
        if (rd_ptr < wr_cnt) begin
          fifo_dout <= src[rd_ptr];
          m_inf_d = src[rd_ptr];
          m_inf = 1'b1;
          rd_ptr <= rd_ptr + 1;
        end else underflow_cnt++;
      end
    end
  end

  task automatic push(input logic [15:0] w);
    src.push_back(w);
    wr_cnt++;
  endtask

  task automatic drive(input logic re, input logic rdy, input logic fl);
    rd_en = re; out_ready = rdy; flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b1, 1'b1, 1'b0);
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    n_chk++; if (readp !== 1'b0) begin n_fail++; $display("FAIL reset_readp: got %b want 0", readp); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", out_data); end
`ifdef FIFO_READER_CNT_EN
    n_chk++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", rd_count); end
`endif
    rstn = 1'b1;
    next_cycle();
    for (int i = 0; i < 4; i++) push(16'hA001 + 16'(i));
    drive(1'b1, 1'b1, 1'b0);
    repeat (3) next_cycle();
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    n_chk++; if (readp !== 1'b1) begin n_fail++; $display("FAIL pre_reset_readp: got %b want 1", readp); end
    #2 rstn = 1'b0;
    #1;
    n_chk++; if (readp !== 1'b0) begin n_fail++; $display("FAIL async_reset_readp: got %b want 0", readp); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL async_reset_data: got %h want 0000", out_data); end
    repeat (2) next_cycle();
    rstn = 1'b1;
    drive(1'b0, 1'b1, 1'b0);
    next_cycle();
  endtask

  // readp seen in cycle i is registered at the following edge; the word is
  // buffered one edge later, so out_valid trails readp by two samples.
  task automatic test_streaming();
    logic [15:0] exp3 [3];
    exp3 = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 3; i++) push(exp3[i]);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++; if (readp !== 1'(i < 3)) begin n_fail++; $display("FAIL stream_readp[%0d]: got %b want %b", i, readp, (i < 3)); end
      n_chk++; if (out_valid !== 1'(i >= 2 && i < 5)) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want %b", i, out_valid, (i >= 2 && i < 5)); end
      if (i >= 2 && i < 5) begin
        n_chk++; if (out_data !== exp3[i-2]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, exp3[i-2]); end
      end
      next_cycle();
    end
`ifdef FIFO_READER_CNT_EN
    n_chk++; if (rd_count !== 16'd3) begin n_fail++; $display("FAIL stream_cnt: got %0d want 3", rd_count); end
`endif
  endtask

  task automatic test_backpressure();
    logic [15:0] exp4 [4];
    int nrp = 0;
    int k = 0;
    exp4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(exp4[i]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nrp += int'(readp);
      if (i >= 2) begin
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
        n_chk++; if (out_data !== 16'h1111) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want 1111", i, out_data); end
      end
      next_cycle();
    end
    n_chk++; if (nrp !== 2) begin n_fail++; $display("FAIL bp_readp_pulses: got %0d want 2", nrp); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (k < 4) begin
          n_chk++; if (out_data !== exp4[k]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", k, out_data, exp4[k]); end
        end
        k++;
      end
      next_cycle();
    end
    n_chk++; if (k !== 4) begin n_fail++; $display("FAIL bp_delivered: got %0d want 4", k); end
  endtask

  task automatic test_empty();
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++; if (readp !== 1'b0) begin n_fail++; $display("FAIL empty_readp[%0d]: got %b want 0", i, readp); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid[%0d]: got %b want 0", i, out_valid); end
      next_cycle();
    end
    n_chk++; if (underflow_cnt !== 0) begin n_fail++; $display("FAIL empty_underflow: got %0d want 0", underflow_cnt); end
  endtask

  task automatic test_flush();
    int t;
    drive(1'b1, 1'b1, 1'b0);
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
    @(negedge clk);
    n_chk++; if (readp !== 1'b1) begin n_fail++; $display("FAIL flush_first_readp: got %b want 1", readp); end
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    n_chk++; if (readp !== 1'b0) begin n_fail++; $display("FAIL flush_readp_held: got %b want 0", readp); end
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
`ifdef FIFO_READER_CNT_EN
    n_chk++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL flush_cnt: got %h want 0000", rd_count); end
`endif
    t = 0;
    while (!out_valid && t < 8) begin next_cycle(); @(negedge clk); t++; end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_resume_timeout: got %b want 1", out_valid); end
    n_chk++; if (out_data !== 16'hBBBB) begin n_fail++; $display("FAIL flush_next_word: got %h want bbbb", out_data); end
    next_cycle();
    idle(6);
    // Flush with both entries occupied drops both buffered words.
    drive(1'b1, 1'b0, 1'b0);
    push(16'h5555); push(16'h6666); push(16'h7777); push(16'h8888);
    repeat (6) next_cycle();
    flush = 1'b1;
    next_cycle();
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_valid: got %b want 0", out_valid); end
    t = 0;
    while (!out_valid && t < 8) begin next_cycle(); @(negedge clk); t++; end
    n_chk++; if (out_data !== 16'h7777) begin n_fail++; $display("FAIL flush_full_next: got %h want 7777", out_data); end
    next_cycle();
    idle(6);
  endtask

  task automatic test_random();
    logic exp_v, exp_rp;
    int   lvl;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) != 0 && (wr_cnt - rd_ptr) < 6) push(16'($urandom));
      rd_en     = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      exp_v  = (mbuf.size() != 0);
      lvl    = mbuf.size() + int'(m_inf) - int'(exp_v && out_ready);
      exp_rp = rd_en && !emptyp && !flush && (lvl < 2);
      n_chk++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        n_chk++; if (out_data !== mbuf[0]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", c, out_data, mbuf[0]); end
      end
      n_chk++; if (readp !== exp_rp) begin n_fail++; $display("FAIL rand_readp[%0d]: got %b want %b", c, readp, exp_rp); end
      next_cycle();
    end
    idle(12);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drained: got %b want 0", out_valid); end
    n_chk++; if (underflow_cnt !== 0) begin n_fail++; $display("FAIL rand_underflow: got %0d want 0", underflow_cnt); end
    next_cycle();
  endtask

`ifdef FIFO_READER_CNT_EN
  task automatic test_cnt_sat();
    drive(1'b0, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    n_chk++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL cnt_flush: got %h want 0000", rd_count); end
    next_cycle();
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 65540; c++) begin
      push(16'(c));
      next_cycle();
    end
    idle(6);
    @(negedge clk);
    n_chk++; if (rd_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffff", rd_count); end
    next_cycle();
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    idle(4);
    test_backpressure();
    idle(4);
    test_empty();
    test_flush();
    test_random();
`ifdef FIFO_READER_CNT_EN
    test_cnt_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
